lcd_seq_ctrl: RTL and testbench

Hardware sequencer for the character LCD on the memory-mapped I/O bus. It performs the HD44780 power-on initialisation by itself. It then accepts command/data bytes from the LSU side over a valid/ready handshake and generates the RS/RW/DATA/EN waveform with guaranteed setup, pulse-width, hold and execution-wait times. Its output word has the same bit layout as the LSU LCD register, so it drives the LCD pins directly and software no longer bit-bangs EN.

---
 rtl/lcd_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lcd_seq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_seq_ctrl.sv
// HD44780 character-LCD sequencer: runs the power-on init ROM, then serialises accepted bytes
// onto RS/RW/DATA/EN with timed setup, EN width, hold and execution wait.
module lcd_seq_ctrl #(
    parameter int POR_WAIT_CYC = 750000,
    parameter int SETUP_CYC    = 2,
    parameter int EN_CYC       = 12,
    parameter int HOLD_CYC     = 2,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_rs,
    input  logic [7:0]  i_req_data,
    output logic        o_busy,
    output logic        o_init_done,
    output logic [31:0] o_lcd
);

    typedef enum logic [2:0] {
        S_POR_WAIT,
        S_LOAD,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_EXEC,
        S_IDLE
    } state_t;

    // Every phase counts down from N-1 and leaves when the count reaches zero.
    localparam logic [19:0] POR_LD   = 20'(POR_WAIT_CYC - 1);
    localparam logic [19:0] SETUP_LD = 20'(SETUP_CYC - 1);
    localparam logic [19:0] EN_LD    = 20'(EN_CYC - 1);
    localparam logic [19:0] HOLD_LD  = 20'(HOLD_CYC - 1);
    localparam logic [19:0] CMD_LD   = 20'(CMD_WAIT_CYC - 1);
    localparam logic [19:0] CLR_LD   = 20'(CLR_WAIT_CYC - 1);
    localparam logic [2:0]  ROM_LEN  = 3'd5;

    state_t      state;
    logic [19:0] cnt;
    logic [2:0]  rom_idx;
    logic        lat_rs;
    logic [7:0]  lat_data;
    logic        lcd_on;
    logic        lcd_en;
    logic        ready;
    logic        busy;
    logic        init_done;
    logic        accept;
    logic        slow_cmd;
    logic        cnt_zero;

    function automatic logic [7:0] rom_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: return 8'h38;
            3'd2:       return 8'h0C;
            3'd3:       return 8'h01;
            default:    return 8'h06;
        endcase
    endfunction

    assign accept   = i_req_valid & ready;
    assign cnt_zero = (cnt == 20'd0);
    // Clear display and return home need the long execution time.
    assign slow_cmd = ~lat_rs & ((lat_data == 8'h01) | (lat_data == 8'h02) | (lat_data == 8'h03));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_POR_WAIT;
            cnt       <= POR_LD;
            rom_idx   <= 3'd0;
            lat_rs    <= 1'b0;
            lat_data  <= 8'h00;
            lcd_on    <= 1'b0;
            lcd_en    <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b1;
            init_done <= 1'b0;
        end else begin
            lcd_on <= 1'b1;
            case (state)
                S_POR_WAIT: begin
                    if (cnt_zero) begin
                        state <= S_LOAD;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                S_LOAD: begin
                    lat_rs   <= 1'b0;
                    lat_data <= rom_byte(rom_idx);
                    rom_idx  <= rom_idx + 3'd1;
                    cnt      <= SETUP_LD;
                    state    <= S_SETUP;
                end
                S_SETUP: begin
                    if (cnt_zero) begin
                        lcd_en <= 1'b1;
                        cnt    <= EN_LD;
                        state  <= S_EN_HI;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                S_EN_HI: begin
                    if (cnt_zero) begin
                        lcd_en <= 1'b0;
                        cnt    <= HOLD_LD;
                        state  <= S_HOLD;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt_zero) begin
                        cnt   <= slow_cmd ? CLR_LD : CMD_LD;
                        state <= S_EXEC;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                S_EXEC: begin
                    if (cnt_zero) begin
                        if (!init_done && (rom_idx != ROM_LEN)) begin
                            state <= S_LOAD;
                        end else begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            ready     <= 1'b1;
                            init_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        lat_rs   <= i_req_rs;
                        lat_data <= i_req_data;
                        cnt      <= SETUP_LD;
                        busy     <= 1'b1;
                        ready    <= 1'b0;
                        state    <= S_SETUP;
                    end
                end
                default: begin
                    state <= S_POR_WAIT;
                    cnt   <= POR_LD;
                    busy  <= 1'b1;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready = ready;
    assign o_busy      = busy;
    assign o_init_done = init_done;
    assign o_lcd       = {lcd_on, 20'd0, lcd_en, lat_rs, 1'b0, lat_data};

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Directed and random bench for lcd_seq_ctrl with reduced timing parameters and a pin scoreboard.
module tb_lcd_seq_ctrl;

    localparam int POR   = 10;
    localparam int SETUP = 2;
    localparam int EN    = 3;
    localparam int HOLD  = 1;
    localparam int CMD   = 5;
    localparam int CLR   = 20;

    typedef struct {
        int         cyc;
        logic       rs;
        logic [7:0] dat;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_rs;
    logic [7:0]  req_data;
    logic        busy;
    logic        init_done;
    logic [31:0] lcd;

    int   checks   = 0;
    int   failures = 0;
    int   cyc;
    ev_t  exp_q[$];
    int   rdy_q[$];

    lcd_seq_ctrl #(
        .POR_WAIT_CYC (POR),
        .SETUP_CYC    (SETUP),
        .EN_CYC       (EN),
        .HOLD_CYC     (HOLD),
        .CMD_WAIT_CYC (CMD),
        .CLR_WAIT_CYC (CLR)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_rs    (req_rs),
        .i_req_data  (req_data),
        .o_busy      (busy),
        .o_init_done (init_done),
        .o_lcd       (lcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge number since reset release: the first rising edge after release is 1.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at cyc %0d", tag, obs, expv, cyc);
        end
    endtask

    // Init bytes: LOAD leaves at edge 11, each byte takes 1+SETUP+EN+HOLD+wait edges.
    task automatic push_init_expect();
        exp_q.push_back('{13, 1'b0, 8'h38});
        exp_q.push_back('{25, 1'b0, 8'h38});
        exp_q.push_back('{37, 1'b0, 8'h0C});
        exp_q.push_back('{49, 1'b0, 8'h01});
        exp_q.push_back('{76, 1'b0, 8'h06});
        rdy_q.push_back(85);
    endtask

    // Pin monitor and scoreboard, sampled on the falling edge.
    initial begin : monitor
        logic       prev_en, prev_rdy, hold_pend, cur_en;
        logic [9:0] d1, d2, cur_d, rise_d;
        int         rise_cyc, a, wt;
        ev_t        e;
        prev_en = 0; prev_rdy = 0; hold_pend = 0; d1 = 0; d2 = 0; rise_d = 0; rise_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_en = 0; prev_rdy = 0; hold_pend = 0; d1 = 0; d2 = 0;
            end else begin
                cur_en = lcd[10];
                cur_d  = lcd[9:0];
                if (hold_pend) begin
                    check("hold_after_fall", 32'(cur_d), 32'(rise_d));
                    hold_pend = 0;
                end
                if (cur_en && !prev_en) begin
                    check("setup_m1", 32'(d1), 32'(cur_d));
                    check("setup_m2", 32'(d2), 32'(cur_d));
                    check("rw_zero", 32'(cur_d[8]), 32'd0);
                    check("en_pulse_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("en_rise_cyc", cyc, e.cyc);
                        check("en_rs", 32'(cur_d[9]), 32'(e.rs));
                        check("en_data", 32'(cur_d[7:0]), 32'(e.dat));
                    end
                    rise_cyc = cyc;
                    rise_d   = cur_d;
                end
                if (!cur_en && prev_en) begin
                    check("en_width", cyc - rise_cyc, EN);
                    check("hold_at_fall", 32'(cur_d), 32'(rise_d));
                    hold_pend = 1;
                end
                if (req_ready && !prev_rdy) begin
                    check("ready_expected", 32'(rdy_q.size() > 0), 32'd1);
                    if (rdy_q.size() > 0) check("ready_cyc", cyc, rdy_q.pop_front());
                    check("busy_when_ready", 32'(busy), 32'd0);
                    check("init_done_when_ready", 32'(init_done), 32'd1);
                end
                if (req_valid && req_ready) begin
                    a  = cyc + 1;
                    wt = (!req_rs && (req_data >= 8'h01) && (req_data <= 8'h03)) ? CLR : CMD;
                    exp_q.push_back('{a + SETUP, req_rs, req_data});
                    rdy_q.push_back(a + SETUP + EN + HOLD + wt);
                end
                d2 = d1; d1 = cur_d; prev_en = cur_en; prev_rdy = req_ready;
            end
        end
    end

    task automatic send(input logic rs, input logic [7:0] d, output int waits);
        @(posedge clk); #1;
        req_valid = 1'b1; req_rs = rs; req_data = d;
        waits = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (req_ready) break;
            waits++;
        end
        if (waits == 500) check("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n == 1000) check(tag, 32'(req_ready), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_lcd"}, lcd, 32'h0000_0000);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_init_done"}, 32'(init_done), 32'd0);
    endtask

    initial begin : stimulus
        int w;
        rst = 1'b1; req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
        push_init_expect();
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        rst = 1'b0;
        check("on_before_edge", 32'(lcd[31]), 32'd0);
        @(negedge clk);
        check("on_after_edge", 32'(lcd[31]), 32'd1);
        check("en_low_por", 32'(lcd[10]), 32'd0);

        // Held valid across the whole init; data character 'A'.
        send(1'b1, 8'h41, w);
        check("held_through_init", 32'(w > 50), 32'd1);
        // Back-to-back requests: clear vs set-DDRAM, second held during the first.
        send(1'b0, 8'h01, w);
        send(1'b0, 8'h80, w);
        wait_ready("idle_timeout_a");
        send(1'b1, 8'h42, w);
        check("accept_1cyc", w, 0);

        // Reset while EN is high in a user transfer.
        wait_ready("idle_timeout_b");
        send(1'b1, 8'h5A, w);
        w = 0;
        while (!lcd[10] && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("en_seen_before_reset", 32'(lcd[10]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("midpulse");
        exp_q.delete();
        rdy_q.delete();
        push_init_expect();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ready("reinit_timeout");
        check("reinit_done", 32'(init_done), 32'd1);

        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), w);
        end
        wait_ready("final_timeout");
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("ready_queue_drained", rdy_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
